// File: rtl/rssb_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : rssb_seq_if
// Brief    : Operand/enable/borrow link between rssb_seq and the RSSB core.
// Revision : 1.0
// ============================================================================
interface rssb_seq_if #(
    parameter int BW = 1
);
    logic [1:0][BW-1:0] data_o;
    logic               ena_o;
    logic               flag_i;
    logic [BW-1:0]      result_i;

    modport master (output data_o, ena_o, input flag_i, result_i);
    modport slave  (input data_o, ena_o, output flag_i, result_i);
endinterface
`default_nettype wire

// File: rtl/rssb_seq.sv
`default_nettype none
// ============================================================================
// Module   : rssb_seq
// Brief    : Steps an operand program through the RSSB core, skipping on borrow.
//            Define RSSB_SEQ_CYCCNT_EN to add the steps_o issue counter.
// Revision : 1.0
// ============================================================================
module rssb_seq #(
    parameter int BW     = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             start_i,
    input  wire [AW-1:0]    last_i,
    input  wire             wr_en_i,
    input  wire [AW-1:0]    wr_addr_i,
    input  wire [2*BW-1:0]  wr_data_i,
    rssb_seq_if.master      core,
    output logic            busy_o,
    output logic            done_o,
    output logic [AW-1:0]   pc_o,
    output logic [BW-1:0]   result_o,
    output logic            err_o
`ifdef RSSB_SEQ_CYCCNT_EN
    ,
    output logic [15:0]     steps_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*BW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      r_last;
    logic [3:0]         r_cnt;
    logic               r_skip;
    logic [BW-1:0]      r_result;
    logic               r_err;
    logic               w_sample;
    logic               w_halt;
    logic [AW:0]        w_npc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sample     = 1'b0;
        // One extra bit so a skip from DEPTH-1 lands above last instead of wrapping.
        w_npc        = {1'b0, r_pc} + (r_skip ? (AW+1)'(2) : (AW+1)'(1));
        w_halt       = (w_npc > {1'b0, r_last});
        core.ena_o   = 1'b0;
        core.data_o  = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core.ena_o  = 1'b1;
                core.data_o = r_mem[r_pc];
                busy_o      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                core.data_o = r_mem[r_pc];
                busy_o      = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                busy_o      = 1'b1;
                w_state_nxt = w_halt ? S_HALT : S_ISSUE;
            end
            S_HALT: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= '0;
            r_last   <= '0;
            r_cnt    <= '0;
            r_skip   <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            if (wr_en_i && (r_state != S_IDLE)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_pc   <= '0;
                        r_last <= last_i;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= 4'(SETTLE);
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_sample) begin
                        r_skip   <= core.flag_i;
                        r_result <= core.result_i;
                    end
                end
                S_NEXT: begin
                    if (!w_halt) begin
                        r_pc <= w_npc[AW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Program store: writes only land while idle, so operands cannot change mid-step.
    always_ff @(posedge clk) begin
        if (wr_en_i && (r_state == S_IDLE)) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign pc_o     = r_pc;
    assign result_o = r_result;
    assign err_o    = r_err;

`ifdef RSSB_SEQ_CYCCNT_EN
    logic [15:0] r_steps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_steps <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_steps <= '0;
        end else if ((r_state == S_ISSUE) && (r_steps != 16'hFFFF)) begin
            r_steps <= r_steps + 16'd1;
        end
    end

    assign steps_o = r_steps;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rssb_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rssb_seq
// Brief    : Scoreboard bench for rssb_seq with a program-level reference model.
// Revision : 1.0
// ============================================================================
module tb_rssb_seq;
    localparam int BW     = 1;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int SETTLE = 2;
    localparam int STEP   = SETTLE + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start_i = 1'b0;
    logic [AW-1:0]   last_i = '0;
    logic            wr_en_i = 1'b0;
    logic [AW-1:0]   wr_addr_i = '0;
    logic [2*BW-1:0] wr_data_i = '0;
    logic            busy_o;
    logic            done_o;
    logic [AW-1:0]   pc_o;
    logic [BW-1:0]   result_o;
    logic            err_o;
`ifdef RSSB_SEQ_CYCCNT_EN
    logic [15:0]     steps_o;
`endif

    rssb_seq_if #(.BW(BW)) core ();

    rssb_seq #(.BW(BW), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .last_i    (last_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .core      (core),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .pc_o      (pc_o),
        .result_o  (result_o),
        .err_o     (err_o)
`ifdef RSSB_SEQ_CYCCNT_EN
        ,
        .steps_o   (steps_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              pc;
        logic [2*BW-1:0] data;
        int              cyc;
    } step_t;
    typedef struct {
        int            pc;
        logic [BW-1:0] res;
        int            n;
        int            cyc;
    } done_t;

    step_t           step_q[$];
    done_t           done_q[$];
    logic [2*BW-1:0] ref_mem [DEPTH];
    bit              flag_tab [DEPTH];
    logic [BW-1:0]   res_tab [DEPTH];
    bit              exp_err = 1'b0;
    int              n_checks = 0;
    int              n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Core stand-in: true borrow/result only in the last settle cycle, noise otherwise.
    int k = 100;
    int cur_pc = 0;
    always @(negedge clk) begin
        if (core.ena_o) begin
            k = 0;
            cur_pc = int'(pc_o);
        end else begin
            k = k + 1;
        end
        if (!core.ena_o && k == SETTLE) begin
            core.flag_i   = flag_tab[cur_pc];
            core.result_i = res_tab[cur_pc];
        end else begin
            core.flag_i   = 1'($urandom);
            core.result_i = BW'($urandom);
        end
    end

    // Monitor: pops expectations whenever the DUT issues a step or finishes.
    step_t           ms;
    done_t           md;
    int              wk = 100;
    logic [2*BW-1:0] cur_data = '0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            wk = 100;
        end else begin
            if (core.ena_o) begin
                if (step_q.size() == 0) begin
                    chk("unexpected_ena", 32'(1), 32'(0));
                end else begin
                    ms = step_q.pop_front();
                    chk("ena_pc", 32'(pc_o), ms.pc);
                    chk("ena_data", 32'(core.data_o), 32'(ms.data));
                    chk("ena_cycle", cyc, ms.cyc);
                    chk("ena_busy", 32'(busy_o), 32'(1));
                    cur_data = ms.data;
                    wk = 0;
                end
            end else begin
                wk++;
                if (wk == SETTLE) chk("wait_data", 32'(core.data_o), 32'(cur_data));
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(1), 32'(0));
                end else begin
                    md = done_q.pop_front();
                    chk("done_pc", 32'(pc_o), md.pc);
                    chk("done_result", 32'(result_o), 32'(md.res));
                    chk("done_cycle", cyc, md.cyc);
                    chk("done_busy", 32'(busy_o), 32'(0));
                    chk("done_err", 32'(err_o), 32'(exp_err));
`ifdef RSSB_SEQ_CYCCNT_EN
                    chk("done_steps", 32'(steps_o), md.n);
`endif
                end
            end
        end
    end

    task automatic write_mem(input int a, input logic [2*BW-1:0] d);
        @(negedge clk);
        wr_en_i = 1'b1;
        wr_addr_i = AW'(a);
        wr_data_i = d;
        ref_mem[a] = d;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    // Issues start and predicts the whole run from the program and borrow table.
    task automatic start_run(input int last, input bit wr, input int wa, input logic [2*BW-1:0] wd);
        int    pc;
        int    npc;
        int    n;
        int    c;
        step_t s;
        done_t d;
        @(negedge clk);
        c = cyc;
        start_i = 1'b1;
        last_i = AW'(last);
        if (wr) begin
            wr_en_i = 1'b1;
            wr_addr_i = AW'(wa);
            wr_data_i = wd;
            ref_mem[wa] = wd;
        end
        pc = 0;
        n = 0;
        forever begin
            s.pc = pc;
            s.data = ref_mem[pc];
            s.cyc = c + 1 + n * STEP;
            step_q.push_back(s);
            n++;
            npc = pc + (flag_tab[pc] ? 2 : 1);
            if (npc > last) break;
            pc = npc;
        end
        d.pc = pc;
        d.res = res_tab[pc];
        d.n = n;
        d.cyc = c + n * STEP + 1;
        done_q.push_back(d);
        @(negedge clk);
        start_i = 1'b0;
        wr_en_i = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while ((step_q.size() != 0 || done_q.size() != 0) && i < 1000) begin
            @(negedge clk);
            i++;
        end
        chk("run_complete", step_q.size() + done_q.size(), 0);
        step_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic set_flags(input int skip_at);
        for (int i = 0; i < DEPTH; i++) begin
            flag_tab[i] = (i == skip_at);
            res_tab[i] = BW'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ena", 32'(core.ena_o), 32'(0));
        chk("rst_data", 32'(core.data_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_pc", 32'(pc_o), 32'(0));
        chk("rst_result", 32'(result_o), 32'(0));
        chk("rst_err", 32'(err_o), 32'(0));
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) write_mem(a, 2*BW'($urandom_range(0, 3)));

        set_flags(-1);
        start_run(3, 1'b0, 0, '0);
        wait_done();

        set_flags(1);
        start_run(5, 1'b0, 0, '0);
        wait_done();

        set_flags(4);
        start_run(5, 1'b0, 0, '0);
        wait_done();

        set_flags(DEPTH - 2);
        start_run(DEPTH - 1, 1'b0, 0, '0);
        wait_done();

        // Write and start while busy: both must be ignored apart from err_o.
        for (int i = 0; i < DEPTH; i++) begin
            flag_tab[i] = 1'($urandom);
            res_tab[i] = BW'($urandom);
        end
        start_run(7, 1'b0, 0, '0);
        @(negedge clk);
        wr_en_i = 1'b1;
        wr_addr_i = AW'(2);
        wr_data_i = ~ref_mem[2];
        exp_err = 1'b1;
        @(negedge clk);
        wr_en_i = 1'b0;
        start_i = 1'b1;
        last_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        wait_done();
        chk("err_sticky", 32'(err_o), 32'(1));

        // Reset while waiting on the second step aborts the run without done.
        set_flags(-1);
        for (int i = 0; i < DEPTH; i++) res_tab[i] = 1'b1;
        start_run(7, 1'b0, 0, '0);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_o), 32'(1));
        chk("pre_rst_pc", 32'(pc_o), 32'(1));
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ena", 32'(core.ena_o), 32'(0));
        chk("mid_rst_data", 32'(core.data_o), 32'(0));
        chk("mid_rst_busy", 32'(busy_o), 32'(0));
        chk("mid_rst_done", 32'(done_o), 32'(0));
        chk("mid_rst_pc", 32'(pc_o), 32'(0));
        chk("mid_rst_result", 32'(result_o), 32'(0));
        chk("mid_rst_err", 32'(err_o), 32'(0));
        step_q.delete();
        done_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * STEP) @(negedge clk);

        // Write committed in the same cycle as start is seen by the first fetch.
        set_flags(-1);
        start_run(DEPTH - 1, 1'b1, 0, ~ref_mem[0]);
        wait_done();

        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < 3; w++) write_mem($urandom_range(0, DEPTH - 1), 2*BW'($urandom_range(0, 3)));
            for (int i = 0; i < DEPTH; i++) begin
                flag_tab[i] = ($urandom_range(0, 3) == 0);
                res_tab[i] = BW'($urandom);
            end
            start_run($urandom_range(0, DEPTH - 1), 1'b0, 0, '0);
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
